led_walk_sequencer: RTL and testbench

//  Command-driven controller for the LED walk pattern. It accepts a run command over a

---
 rtl/led_seq_pkg.sv | 26 ++
 rtl/led_step_timer.sv | 31 +++
 rtl/led_walk_sequencer.sv | 137 +++++++++++++
 tb/tb_led_walk_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED walk sequencer: FSM state encoding and
// bounce-geometry helpers. Ports: none (package).
package led_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

   localparam int unsigned NLEDS_DEF = 8;

   // Steps in one full bounce (out and back) across nleds outputs
   function automatic int unsigned period_f(input int unsigned nleds);
      return 2 * (nleds - 1);
   endfunction

   // Width of the position register for an nleds-wide bar
   function automatic int unsigned pos_w_f(input int unsigned nleds);
      return $clog2(period_f(nleds));
   endfunction

   localparam int unsigned PERIOD = period_f(NLEDS_DEF);
   localparam int unsigned POS_W  = pos_w_f(NLEDS_DEF);

endpackage

// File: rtl/led_step_timer.sv
// Loadable step divider: counts 0..i_div and raises o_strobe on the terminal
// count, then wraps. i_clear forces the count to zero.
// Ports: i_clk, i_reset (async, active-high), i_clear, i_div, o_strobe.
module led_step_timer #(
   parameter int unsigned DIV_W = 24
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clear,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_strobe
);

   logic [DIV_W-1:0] cnt_q;

   // Strobe is decoded from the count so step k lands exactly k*(div+1) edges in
   assign o_strobe = (cnt_q == i_div);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt_q <= '0;
      end else if (i_clear || o_strobe) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + DIV_W'(1);
      end
   end

   a_cnt_le_div: assert property (@(posedge i_clk) disable iff (i_reset) cnt_q <= i_div);

endmodule

// File: rtl/led_walk_sequencer.sv
// Command-driven LED walk controller: accepts {div, sweeps} over valid/ready,
// bounces one lit LED across NLEDS outputs once per step, reports busy/done.
// Ports: i_clk, i_reset (async, active-high), i_cmd_valid/o_cmd_ready,
//        i_cmd_div, i_cmd_sweeps, i_abort, o_busy, o_done, o_led (one-hot).
module led_walk_sequencer
   import led_seq_pkg::*;
#(
   parameter int unsigned NLEDS = NLEDS_DEF,
   parameter int unsigned DIV_W = 24,
   parameter int unsigned SWP_W = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [DIV_W-1:0] i_cmd_div,
   input  logic [SWP_W-1:0] i_cmd_sweeps,
   input  logic             i_abort,
   output logic             o_busy,
   output logic             o_done,
   output logic [NLEDS-1:0] o_led
);

   localparam int unsigned STEPS = period_f(NLEDS);
   localparam int unsigned PW    = pos_w_f(NLEDS);

   seq_state_e       state_q;
   logic [DIV_W-1:0] div_q;
   logic [SWP_W-1:0] sweeps_q;
   logic [SWP_W-1:0] swd_q;
   logic [PW-1:0]    pos_q;
   logic [NLEDS-1:0] led_q;
   logic             busy_q;
   logic             done_q;
   logic             ready_q;

   logic             strobe_c;
   logic             wrap_c;
   logic             last_c;
   logic [PW-1:0]    pos_inc_c;
   logic [PW-1:0]    idx_c;
   logic [SWP_W-1:0] swd_inc_c;
   logic [NLEDS-1:0] led_nxt_c;

   // Divider is held cleared outside RUN so the first step is div+1 edges after accept
   led_step_timer #(
      .DIV_W (DIV_W)
   ) u_timer (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_clear  (state_q != ST_RUN),
      .i_div    (div_q),
      .o_strobe (strobe_c)
   );

   // Next position and its LED: positions past the far end fold back toward bit 0
   always_comb begin
      wrap_c    = (pos_q == PW'(STEPS - 1));
      pos_inc_c = wrap_c ? '0 : pos_q + PW'(1);
      idx_c     = (32'(pos_inc_c) < NLEDS) ? pos_inc_c : PW'(STEPS - 32'(pos_inc_c));
      led_nxt_c = NLEDS'(1) << idx_c;
      swd_inc_c = swd_q + SWP_W'(1);
      last_c    = (sweeps_q != '0) && (swd_inc_c == sweeps_q);
   end

   // Sequencer FSM with registered outputs
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= ST_IDLE;
         div_q    <= '0;
         sweeps_q <= '0;
         swd_q    <= '0;
         pos_q    <= '0;
         led_q    <= NLEDS'(1);
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               led_q <= NLEDS'(1);
               if (i_cmd_valid && ready_q) begin
                  div_q    <= i_cmd_div;
                  sweeps_q <= i_cmd_sweeps;
                  swd_q    <= '0;
                  pos_q    <= '0;
                  state_q  <= ST_RUN;
                  busy_q   <= 1'b1;
                  ready_q  <= 1'b0;
               end
            end
            ST_RUN: begin
               // Abort takes priority over a coincident step or completion
               if (i_abort) begin
                  state_q <= ST_IDLE;
                  led_q   <= NLEDS'(1);
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
               end else if (strobe_c) begin
                  pos_q <= pos_inc_c;
                  led_q <= led_nxt_c;
                  if (wrap_c) begin
                     swd_q <= swd_inc_c;
                     if (last_c) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
               led_q   <= NLEDS'(1);
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign o_led       = led_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_cmd_ready = ready_q;

   a_led_onehot: assert property (@(posedge i_clk) disable iff (i_reset) $onehot(o_led));
   a_pos_range:  assert property (@(posedge i_clk) disable iff (i_reset) 32'(pos_q) < STEPS);
   a_busy_run:   assert property (@(posedge i_clk) disable iff (i_reset)
                                  busy_q == (state_q == ST_RUN));

endmodule

// File: tb/tb_led_walk_sequencer.sv
// Self-checking bench for led_walk_sequencer: an 8-LED and a 4-LED instance,
// per-cycle expected {ready,busy,done,led} words queued by the stimulus tasks
// and compared on the falling edge.
module tb_led_walk_sequencer;

   localparam int unsigned DIV_W = 24;
   localparam int unsigned SWP_W = 8;

   logic clk = 1'b0;
   logic rst;

   logic             v8, r8, ab8, busy8, done8;
   logic [DIV_W-1:0] d8;
   logic [SWP_W-1:0] s8;
   logic [7:0]       led8;

   logic             v4, r4, ab4, busy4, done4;
   logic [DIV_W-1:0] d4;
   logic [SWP_W-1:0] s4;
   logic [3:0]       led4;

   led_walk_sequencer #(.NLEDS(8), .DIV_W(DIV_W), .SWP_W(SWP_W)) u_dut8 (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_cmd_valid  (v8),
      .o_cmd_ready  (r8),
      .i_cmd_div    (d8),
      .i_cmd_sweeps (s8),
      .i_abort      (ab8),
      .o_busy       (busy8),
      .o_done       (done8),
      .o_led        (led8)
   );

   led_walk_sequencer #(.NLEDS(4), .DIV_W(DIV_W), .SWP_W(SWP_W)) u_dut4 (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_cmd_valid  (v4),
      .o_cmd_ready  (r4),
      .i_cmd_div    (d4),
      .i_cmd_sweeps (s4),
      .i_abort      (ab4),
      .o_busy       (busy4),
      .o_done       (done4),
      .o_led        (led4)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [10:0] q8[$];
   logic [10:0] q4[$];
   string       tag8 = "init";
   string       tag4 = "init";

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [10:0] pk(input logic ready, input logic busy, input logic done,
                                      input logic [7:0] led);
      return {ready, busy, done, led};
   endfunction

   task automatic push_exp(input int which, input logic [10:0] val);
      if (which == 8) q8.push_back(val);
      else            q4.push_back(val);
   endtask

   task automatic push_idle(input int which, input int n);
      for (int i = 0; i < n; i++) push_exp(which, pk(1'b1, 1'b0, 1'b0, 8'h01));
   endtask

   // Expected state after edge E0+k, from the closed-form step schedule
   task automatic push_run(input int which, input int nleds, input int div, input int sweeps,
                           input int kmax);
      int       period;
      int       kc;
      int       s;
      int       p;
      int       idx;
      logic [7:0] led;
      period = 2 * (nleds - 1);
      kc     = sweeps * period * (div + 1);
      for (int k = 0; k < kmax; k++) begin
         if (sweeps != 0 && k == kc) begin
            push_exp(which, pk(1'b0, 1'b0, 1'b1, 8'h01));
            push_exp(which, pk(1'b1, 1'b0, 1'b0, 8'h01));
            return;
         end
         s   = k / (div + 1);
         p   = s % period;
         idx = (p < nleds) ? p : period - p;
         led = 8'h01 << idx;
         push_exp(which, pk(1'b0, 1'b1, 1'b0, led));
      end
   endtask

   // Present a command for one edge (E0); returns just after E0
   task automatic start_cmd(input int which, input int div, input int sweeps);
      if (which == 8) begin
         v8 = 1'b1; d8 = DIV_W'(div); s8 = SWP_W'(sweeps);
      end else begin
         v4 = 1'b1; d4 = DIV_W'(div); s4 = SWP_W'(sweeps);
      end
      @(posedge clk);
      #1;
      v8 = 1'b0;
      v4 = 1'b0;
   endtask

   task automatic drain(input int limit);
      int n;
      n = 0;
      while ((q8.size() != 0 || q4.size() != 0) && n < limit) begin
         @(posedge clk);
         n++;
      end
      if (q8.size() != 0 || q4.size() != 0) begin
         check_eq("drain_timeout", 32'(q8.size() + q4.size()), 32'd0);
         q8.delete();
         q4.delete();
      end
      #1;
   endtask

   always @(negedge clk) begin
      logic [10:0] e;
      if (q8.size() != 0) begin
         e = q8.pop_front();
         check_eq(tag8, 32'({r8, busy8, done8, led8}), 32'(e));
      end
      if (q4.size() != 0) begin
         e = q4.pop_front();
         check_eq(tag4, 32'({r4, busy4, done4, 4'b0000, led4}), 32'(e));
      end
   end

   initial begin
      rst = 1'b1;
      v8 = 1'b0; ab8 = 1'b0; d8 = '0; s8 = '0;
      v4 = 1'b0; ab4 = 1'b0; d4 = '0; s4 = '0;
      #2;
      check_eq("reset8", 32'({r8, busy8, done8, led8}), 32'(pk(1'b1, 1'b0, 1'b0, 8'h01)));
      check_eq("reset4", 32'({r4, busy4, done4, 4'b0000, led4}), 32'(pk(1'b1, 1'b0, 1'b0, 8'h01)));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      tag8 = "t1_idle8"; tag4 = "t1_idle4";
      push_idle(8, 20);
      push_idle(4, 5);
      drain(100);

      tag8 = "t2_div2_sw1";
      start_cmd(8, 2, 1);
      push_run(8, 8, 2, 1, 1000);
      drain(200);

      tag8 = "t3_div0_sw3";
      start_cmd(8, 0, 3);
      push_run(8, 8, 0, 3, 1000);
      drain(200);

      tag8 = "t4_endless_abort";
      start_cmd(8, 1, 0);
      push_run(8, 8, 1, 0, 1100);
      repeat (1099) @(posedge clk);
      #1;
      ab8 = 1'b1;
      push_idle(8, 4);
      @(posedge clk);
      #1;
      ab8 = 1'b0;
      drain(50);

      tag8 = "t4_abort_idle";
      ab8 = 1'b1;
      push_idle(8, 3);
      repeat (2) @(posedge clk);
      #1;
      ab8 = 1'b0;
      drain(50);

      tag8 = "t5_abort_on_done";
      start_cmd(8, 1, 1);
      push_run(8, 8, 1, 1, 28);
      repeat (27) @(posedge clk);
      #1;
      ab8 = 1'b1;
      push_idle(8, 3);
      @(posedge clk);
      #1;
      ab8 = 1'b0;
      drain(50);

      tag8 = "t5_valid_held";
      v8 = 1'b1; d8 = '0; s8 = SWP_W'(1);
      @(posedge clk);
      #1;
      d8 = DIV_W'(7);
      push_run(8, 8, 0, 1, 100);
      push_run(8, 8, 0, 1, 100);
      repeat (14) @(posedge clk);
      #1;
      d8 = '0;
      repeat (2) @(posedge clk);
      #1;
      v8 = 1'b0;
      drain(100);

      tag8 = "t5_reset_midrun";
      start_cmd(8, 1, 2);
      push_run(8, 8, 1, 2, 9);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_eq("t5_reset_async", 32'({r8, busy8, done8, led8}), 32'(pk(1'b1, 1'b0, 1'b0, 8'h01)));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      push_idle(8, 5);
      drain(50);

      tag4 = "t6_n4_div0_sw2";
      start_cmd(4, 0, 2);
      push_run(4, 4, 0, 2, 100);
      drain(100);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
